// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Results are computed at start and held pending until the fixed latency expires.
module md_unit #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  mdop,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mdwe,
   input  logic        hilo,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rdata
);

   // state  | meaning
   // S_IDLE | accepting start / MTHI / MTLO
   // S_RUN  | operation in flight, counting down to commit
   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [63:0]   r_pend;
   logic          r_pend_we;
   logic          r_busy;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;

   logic          w_start_ok;
   logic          w_commit;
   logic          w_mtx;

   logic          w_is_div;
   logic          w_signed;
   logic          w_a_neg;
   logic          w_b_neg;
   logic [63:0]   w_ext_a;
   logic [63:0]   w_ext_b;
   logic [63:0]   w_prod;
   logic [31:0]   w_dnd;
   logic [31:0]   w_dsr_raw;
   logic [31:0]   w_dsr;
   logic [31:0]   w_q_mag;
   logic [31:0]   w_r_mag;
   logic [31:0]   w_quot;
   logic [31:0]   w_rem;
   logic [63:0]   w_res;
   logic          w_res_we;
   logic [CW-1:0] w_lat_ld;

   always_comb begin
      w_state_nxt = r_state;
      w_start_ok  = 1'b0;
      w_commit    = 1'b0;
      w_mtx       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_start_ok  = 1'b1;
               w_state_nxt = S_RUN;
            end else if (mdwe) begin
               w_mtx = 1'b1;
            end
         end
         S_RUN: begin
            if (r_cnt == '0) begin
               w_commit    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Sign-extending to 64 bits lets one unsigned multiplier serve MULT and MULTU.
   assign w_is_div  = mdop[1];
   assign w_signed  = ~mdop[0];
   assign w_a_neg   = w_signed & a[31];
   assign w_b_neg   = w_signed & b[31];
   assign w_ext_a   = {{32{w_a_neg}}, a};
   assign w_ext_b   = {{32{w_b_neg}}, b};
   assign w_prod    = w_ext_a * w_ext_b;

   // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign w_dnd     = w_a_neg ? (~a + 32'd1) : a;
   assign w_dsr_raw = w_b_neg ? (~b + 32'd1) : b;
   assign w_dsr     = (b == 32'd0) ? 32'd1 : w_dsr_raw;
   assign w_q_mag   = w_dnd / w_dsr;
   assign w_r_mag   = w_dnd % w_dsr;
   assign w_quot    = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
   assign w_rem     = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

   assign w_res     = w_is_div ? {w_rem, w_quot} : w_prod;
   assign w_res_we  = ~(w_is_div & (b == 32'd0));
   assign w_lat_ld  = w_is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_busy    <= 1'b0;
         r_cnt     <= '0;
         r_pend    <= '0;
         r_pend_we <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == S_RUN);
         if (w_start_ok) begin
            r_cnt     <= w_lat_ld;
            r_pend    <= w_res;
            r_pend_we <= w_res_we;
         end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_commit && r_pend_we) begin
            r_hi <= r_pend[63:32];
            r_lo <= r_pend[31:0];
         end else if (w_mtx) begin
            if (hilo) r_hi <= a;
            else      r_lo <= a;
         end
      end
   end

   assign busy  = r_busy;
   assign hi    = r_hi;
   assign lo    = r_lo;
   assign rdata = hilo ? r_hi : r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO and latency,
// a negedge monitor pops and compares whenever busy falls.
module tb_md_unit;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  mdop;
   logic [31:0] a;
   logic [31:0] b;
   logic        mdwe;
   logic        hilo;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rdata;

   md_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mdop  (mdop),
      .a     (a),
      .b     (b),
      .mdwe  (mdwe),
      .hilo  (hilo),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo),
      .rdata (rdata)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   int          checks;
   int          errors;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model in plain 64-bit arithmetic.
   task automatic ref_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ch, input logic [31:0] cl,
                         output logic [31:0] nh, output logic [31:0] nl);
      longint          sx;
      longint          sy;
      longint          sq;
      longint          sr;
      logic [63:0]     up;
      nh = ch;
      nl = cl;
      case (op)
         2'b00: begin
            sq = longint'($signed(av)) * longint'($signed(bv));
            nh = sq[63:32];
            nl = sq[31:0];
         end
         2'b01: begin
            up = {32'd0, av} * {32'd0, bv};
            nh = up[63:32];
            nl = up[31:0];
         end
         2'b10: begin
            if (bv != 32'd0) begin
               sx = longint'($signed(av));
               sy = longint'($signed(bv));
               sq = sx / sy;
               sr = sx % sy;
               nl = sq[31:0];
               nh = sr[31:0];
            end
         end
         default: begin
            if (bv != 32'd0) begin
               nl = av / bv;
               nh = av % bv;
            end
         end
      endcase
   endtask

   initial begin : monitor
      int   bcnt;
      logic prev;
      exp_t e;
      bcnt = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb_q.delete();
            bcnt = 0;
            prev = 1'b0;
         end else begin
            if (busy) bcnt++;
            if (prev && !busy) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected: busy fell with no expected result at %0t", $time);
               end else begin
                  e = sb_q.pop_front();
                  chk("sb_hi", hi, e.hi);
                  chk("sb_lo", lo, e.lo);
                  chk("sb_busy_cycles", 32'(bcnt), 32'(e.lat));
               end
               bcnt = 0;
            end
            prev = busy;
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 200) begin
            chk("idle_timeout", {31'd0, busy}, 32'd0);
            break;
         end
      end
   endtask

   task automatic issue_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                           input logic with_mdwe, input logic inject);
      logic [31:0] nh;
      logic [31:0] nl;
      exp_t        e;
      wait_idle();
      @(posedge clk);
      #1;
      start = 1'b1;
      mdop  = op;
      a     = av;
      b     = bv;
      mdwe  = with_mdwe;
      hilo  = 1'b1;
      ref_op(op, av, bv, m_hi, m_lo, nh, nl);
      e.hi  = nh;
      e.lo  = nl;
      e.lat = op[1] ? DIV_LAT : MUL_LAT;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      mdwe  = 1'b0;
      a     = $urandom;
      b     = $urandom;
      mdop  = 2'($urandom);
      chk("busy_rise", {31'd0, busy}, 32'd1);
      chk("rdata_old_hi", rdata, m_hi);
      if (inject) begin
         repeat (3) @(posedge clk);
         #1;
         start = 1'b1;
         mdwe  = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         mdwe  = 1'b0;
      end
      m_hi = nh;
      m_lo = nl;
      wait_idle();
   endtask

   task automatic move_to(input logic sel, input logic [31:0] v);
      wait_idle();
      @(posedge clk);
      #1;
      mdwe = 1'b1;
      hilo = sel;
      a    = v;
      @(posedge clk);
      #1;
      mdwe = 1'b0;
      a    = $urandom;
      if (sel) m_hi = v;
      else     m_lo = v;
      chk("mt_hi", hi, m_hi);
      chk("mt_lo", lo, m_lo);
      chk("mt_busy", {31'd0, busy}, 32'd0);
      chk("mt_rdata", rdata, v);
   endtask

   task automatic chk_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
      @(negedge clk);
      chk({name, "_hi"}, hi, eh);
      chk({name, "_lo"}, lo, el);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [1:0]  op;
      logic [31:0] av;
      logic [31:0] bv;
      checks = 0;
      errors = 0;
      m_hi   = '0;
      m_lo   = '0;
      rst_n  = 1'b0;
      start  = 1'b0;
      mdop   = 2'b00;
      a      = '0;
      b      = '0;
      mdwe   = 1'b0;
      hilo   = 1'b0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      issue_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
      chk_hl("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      issue_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk_hl("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
      issue_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      chk_hl("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      move_to(1'b1, 32'h11);
      move_to(1'b0, 32'h22);
      issue_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b1);
      chk_hl("divu_zero", 32'h11, 32'h22);
      move_to(1'b1, 32'hCAFE_BABE);
      issue_op(2'b00, 32'd6, 32'd7, 1'b1, 1'b0);
      chk_hl("mult_mdwe", 32'd0, 32'd42);
      issue_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk_hl("div_ovf", 32'd0, 32'h8000_0000);
      issue_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
      chk_hl("div_negdiv", 32'd1, 32'hFFFF_FFFD);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom);
         av = $urandom;
         bv = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) bv = 32'($urandom_range(1, 20));
         if ($urandom_range(0, 4) == 0) move_to(1'($urandom), $urandom);
         issue_op(op, av, bv, 1'($urandom), 1'($urandom_range(0, 3) == 0) & op[1]);
      end

      wait_idle();
      @(posedge clk);
      #1;
      start = 1'b1;
      mdop  = 2'b10;
      a     = 32'd100;
      b     = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_hi  = '0;
      m_lo  = '0;
      repeat (DIV_LAT + 3) @(posedge clk);
      #1;
      chk("abort_no_commit_busy", {31'd0, busy}, 32'd0);
      chk("abort_no_commit_hi", hi, 32'd0);
      chk("abort_no_commit_lo", lo, 32'd0);

      issue_op(2'b01, 32'd9, 32'd9, 1'b0, 1'b0);
      chk_hl("post_abort", 32'd0, 32'd81);
      @(negedge clk);
      @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
